demux_frame_capture: RTL and testbench

//  Write-side counterpart of the 7:1 bit-select mux: routes a serial bit Din into one of 7 slots.

---
 rtl/demux_frame_capture_pkg.sv | 13 +
 rtl/demux_frame_capture_if.sv | 27 ++
 rtl/demux_frame_capture_slot_decoder.sv | 22 ++
 rtl/demux_frame_capture.sv | 108 ++++++++++
 tb/tb_demux_frame_capture.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/demux_frame_capture_pkg.sv
// Shared constants and state encoding for the 7-slot demux / frame capture block.
package demux_pkg;

    localparam int SLOTS = 7;
    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] SEL_INVALID = 3'b111;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

endpackage

// File: rtl/demux_frame_capture_if.sv
// Control/data bundle between the capture block and its driver.
interface demux_frame_capture_if;
    import demux_pkg::*;

    logic             i_clear;
    logic             i_load;
    logic             i_mode;
    logic [SEL_W-1:0] i_demuxSelect;
    logic             i_din;
    logic [SLOTS-1:0] o_stage;
    logic [SLOTS-1:0] o_frame;
    logic             o_frameValid;
    logic [SEL_W-1:0] o_slotPtr;
    logic             o_busy;
    logic             o_selErr;

    modport master (
        output i_clear, i_load, i_mode, i_demuxSelect, i_din,
        input  o_stage, o_frame, o_frameValid, o_slotPtr, o_busy, o_selErr
    );

    modport slave (
        input  i_clear, i_load, i_mode, i_demuxSelect, i_din,
        output o_stage, o_frame, o_frameValid, o_slotPtr, o_busy, o_selErr
    );

endinterface

// File: rtl/demux_frame_capture_slot_decoder.sv
// Slot index to one-hot write enable; the all-ones index is reported as invalid.
module slot_decoder
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0] i_idx,
    output logic [SLOTS-1:0] o_oneHot,
    output logic             o_valid
);

    logic [SLOTS:0] w_shifted;

    always_comb begin
        w_shifted = (SLOTS+1)'(1) << i_idx;
        o_oneHot  = '0;
        o_valid   = 1'b0;
        if (i_idx != SEL_INVALID) begin
            o_oneHot = w_shifted[SLOTS-1:0];
            o_valid  = 1'b1;
        end
    end

endmodule

// File: rtl/demux_frame_capture.sv
// Routes serial bit Din into one of 7 slots, either addressed or auto-sequenced,
// and snapshots each completed auto frame into Frame with a one-cycle valid pulse.
module demux_frame_capture
    import demux_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    demux_frame_capture_if.slave  bus
);

    state_t           r_state;
    state_t           w_nextState;
    logic [SLOTS-1:0] r_stage;
    logic [SLOTS-1:0] w_stageNext;
    logic [SLOTS-1:0] r_frame;
    logic [SLOTS-1:0] w_frameNext;
    logic [SEL_W-1:0] r_slotPtr;
    logic [SEL_W-1:0] w_slotPtrNext;
    logic             r_frameValid;
    logic             w_frameValidNext;
    logic             r_selErr;
    logic             w_selErrNext;

    logic             w_useAuto;
    logic [SEL_W-1:0] w_idx;
    logic [SLOTS-1:0] w_oneHot;
    logic             w_idxValid;
    logic [SLOTS-1:0] w_stageWritten;

    // SlotPtr rests at 0 in IDLE, so it also addresses slot 0 for the first auto write.
    assign w_useAuto = (r_state == FILL) || bus.i_mode;
    assign w_idx     = w_useAuto ? r_slotPtr : bus.i_demuxSelect;

    slot_decoder u_slotDecoder (
        .i_idx    (w_idx),
        .o_oneHot (w_oneHot),
        .o_valid  (w_idxValid)
    );

    assign w_stageWritten = (r_stage & ~w_oneHot) | (w_oneHot & {SLOTS{bus.i_din}});

    always_comb begin
        w_nextState      = r_state;
        w_stageNext      = r_stage;
        w_frameNext      = r_frame;
        w_slotPtrNext    = r_slotPtr;
        w_frameValidNext = 1'b0;
        w_selErrNext     = 1'b0;

        if (bus.i_clear) begin
            w_stageNext   = '0;
            w_slotPtrNext = '0;
            w_nextState   = IDLE;
        end else if (bus.i_load) begin
            unique case (r_state)
                IDLE: begin
                    if (bus.i_mode) begin
                        w_stageNext   = w_stageWritten;
                        w_slotPtrNext = SEL_W'(1);
                        w_nextState   = FILL;
                    end else if (w_idxValid) begin
                        w_stageNext = w_stageWritten;
                    end else begin
                        w_selErrNext = 1'b1;
                    end
                end
                FILL: begin
                    w_stageNext = w_stageWritten;
                    if (r_slotPtr == SEL_W'(SLOTS-1)) begin
                        w_frameNext      = {bus.i_din, r_stage[SLOTS-2:0]};
                        w_frameValidNext = 1'b1;
                        w_slotPtrNext    = '0;
                        w_nextState      = IDLE;
                    end else begin
                        w_slotPtrNext = r_slotPtr + SEL_W'(1);
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_stage      <= '0;
            r_frame      <= '0;
            r_slotPtr    <= '0;
            r_frameValid <= 1'b0;
            r_selErr     <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_stage      <= w_stageNext;
            r_frame      <= w_frameNext;
            r_slotPtr    <= w_slotPtrNext;
            r_frameValid <= w_frameValidNext;
            r_selErr     <= w_selErrNext;
        end
    end

    assign bus.o_stage      = r_stage;
    assign bus.o_frame      = r_frame;
    assign bus.o_frameValid = r_frameValid;
    assign bus.o_slotPtr    = r_slotPtr;
    assign bus.o_busy       = (r_state == FILL);
    assign bus.o_selErr     = r_selErr;

endmodule

// File: tb/tb_demux_frame_capture.sv
// Directed bench for demux_frame_capture: addressed writes, auto frames, clear and async reset.
module tb_demux_frame_capture;

    logic clk;
    logic rst;
    int   vectorCount;
    int   missCount;
    int   pulseCount;

    demux_frame_capture_if busIf ();

    demux_frame_capture dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
    task automatic applyStimulus(input logic clr, input logic ld, input logic md,
                                 input logic [2:0] sel, input logic d);
        @(negedge clk);
        busIf.i_clear       = clr;
        busIf.i_load        = ld;
        busIf.i_mode        = md;
        busIf.i_demuxSelect = sel;
        busIf.i_din         = d;
        @(posedge clk);
        #1;
        if (busIf.o_frameValid === 1'b1) pulseCount++;
    endtask

    initial begin
        logic [6:0] pattern;
        logic       sawValid;

        vectorCount = 0;
        missCount   = 0;
        pulseCount  = 0;
        rst = 1'b1;
        busIf.i_clear       = 1'b0;
        busIf.i_load        = 1'b0;
        busIf.i_mode        = 1'b0;
        busIf.i_demuxSelect = 3'd0;
        busIf.i_din         = 1'b0;

        #12;
        checkOutput("rstStage", 32'(busIf.o_stage), 32'h0);
        checkOutput("rstFrame", 32'(busIf.o_frame), 32'h0);
        checkOutput("rstPtr", 32'(busIf.o_slotPtr), 32'h0);
        checkOutput("rstFlags", {29'd0, busIf.o_frameValid, busIf.o_busy, busIf.o_selErr}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Addressed writes to every slot
        pattern  = 7'b1001101;
        sawValid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 3'(i), pattern[i]);
            if (busIf.o_frameValid === 1'b1) sawValid = 1'b1;
        end
        checkOutput("addrStage", 32'(busIf.o_stage), 32'h4D);
        checkOutput("addrNoValid", 32'(sawValid), 32'h0);
        checkOutput("addrPtr", 32'(busIf.o_slotPtr), 32'h0);
        checkOutput("addrBusy", 32'(busIf.o_busy), 32'h0);

        // Invalid select
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b111, 1'b1);
        checkOutput("badSelStage", 32'(busIf.o_stage), 32'h4D);
        checkOutput("badSelErr", 32'(busIf.o_selErr), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b111, 1'b1);
        checkOutput("badSelErrDrop", 32'(busIf.o_selErr), 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        checkOutput("clrStage", 32'(busIf.o_stage), 32'h0);

        // Auto frame; Mode and select toggled during FILL must be ignored
        pattern = 7'b1010011;
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd5, pattern[0]);
        checkOutput("autoBusy", 32'(busIf.o_busy), 32'h1);
        checkOutput("autoPtr1", 32'(busIf.o_slotPtr), 32'h1);
        for (int i = 1; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, 1'(i % 2), 3'b111, pattern[i]);
            if (i == 3) checkOutput("autoNoSelErr", 32'(busIf.o_selErr), 32'h0);
            if (i == 4) checkOutput("autoPtr5", 32'(busIf.o_slotPtr), 32'h5);
        end
        checkOutput("autoFrame", 32'(busIf.o_frame), 32'h53);
        checkOutput("autoValid", 32'(busIf.o_frameValid), 32'h1);
        checkOutput("autoPtrWrap", 32'(busIf.o_slotPtr), 32'h0);
        checkOutput("autoBusyDone", 32'(busIf.o_busy), 32'h0);
        for (int s = 0; s < 7; s++)
            checkOutput($sformatf("muxSel%0d", s), 32'(busIf.o_stage[s]), 32'(pattern[s]));
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        checkOutput("autoValidDrop", 32'(busIf.o_frameValid), 32'h0);
        checkOutput("autoFrameHold", 32'(busIf.o_frame), 32'h53);

        // Gapped frame then back-to-back all-ones frame
        pulseCount = 0;
        pattern    = 7'b0101010;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, pattern[i]);
            if (i < 6) begin
                applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
                applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
                if (i == 2) checkOutput("gapPtrHold", 32'(busIf.o_slotPtr), 32'h3);
            end
        end
        checkOutput("gapFrame", 32'(busIf.o_frame), 32'h2A);
        for (int i = 0; i < 7; i++)
            applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 1'b1);
        checkOutput("b2bFrame", 32'(busIf.o_frame), 32'h7F);
        checkOutput("b2bPulses", 32'(pulseCount), 32'h2);

        // Clear beats Load mid-frame
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        checkOutput("clrPrePtr", 32'(busIf.o_slotPtr), 32'h4);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 1'b1);
        checkOutput("clrLdStage", 32'(busIf.o_stage), 32'h0);
        checkOutput("clrLdPtr", 32'(busIf.o_slotPtr), 32'h0);
        checkOutput("clrLdBusy", 32'(busIf.o_busy), 32'h0);
        checkOutput("clrLdFrame", 32'(busIf.o_frame), 32'h7F);
        checkOutput("clrLdValid", 32'(busIf.o_frameValid), 32'h0);

        // Async reset mid-frame, Mode dropped during FILL
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd6, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd6, 1'b1);
        checkOutput("preRstPtr", 32'(busIf.o_slotPtr), 32'h3);
        checkOutput("preRstStage", 32'(busIf.o_stage), 32'h07);
        busIf.i_load = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncStage", 32'(busIf.o_stage), 32'h0);
        checkOutput("asyncFrame", 32'(busIf.o_frame), 32'h0);
        checkOutput("asyncPtr", 32'(busIf.o_slotPtr), 32'h0);
        checkOutput("asyncBusy", 32'(busIf.o_busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd2, 1'b1);
        checkOutput("postRstAddr", 32'(busIf.o_stage), 32'h04);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
